// File: rtl/fifo_wr_packer_pkg.sv
// Shared types and constants for the FIFO write-side packer.
package fifo_wr_packer_pkg;

    localparam int unsigned WORD_CNT_W = 32;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Width of a lane index for a given pack ratio (at least one bit).
    function automatic int unsigned lane_idx_w(input int unsigned ratio);
        int unsigned w;
        w = $clog2(ratio);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_wr_packer_idle_timer.sv
// Idle counter for the packer's auto-flush: counts while run is high, clears on clear,
// and reports expiry once LIMIT idle cycles have accumulated.
module fifo_wr_packer_idle_timer #(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    // Saturating count of consecutive idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || !run) begin
            count <= '0;
        end else if (count != CNT_W'(LIMIT)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire_c = run && !clear && (count == CNT_W'(LIMIT));

endmodule

// File: rtl/fifo_wr_packer.sv
// Packs PACK_RATIO narrow input words into one FIFO word and drives the FIFO write port.
// Optional idle auto-flush is enabled with `define FIFO_WR_PACKER_TIMEOUT_EN.
module fifo_wr_packer
    import fifo_wr_packer_pkg::*;
#(
    parameter int unsigned IN_WIDTH       = 8,
    parameter int unsigned PACK_RATIO     = 2,
    parameter int unsigned THROTTLE_ON_AF = 0,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                                wr_clk,
    input  logic                                wr_rst_n,
    input  logic [IN_WIDTH-1:0]                 in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                flush,
    output logic                                flush_done,
    output logic [IN_WIDTH*PACK_RATIO-1:0]      fifo_wr_data,
    output logic                                fifo_wr_en,
    input  logic                                fifo_full,
    input  logic                                fifo_almost_full,
    output logic [lane_idx_w(PACK_RATIO)-1:0]   lane_cnt,
    output logic [WORD_CNT_W-1:0]               word_cnt
);

    localparam int unsigned OUT_WIDTH = IN_WIDTH * PACK_RATIO;
    localparam int unsigned LANE_W    = lane_idx_w(PACK_RATIO);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK_RATIO - 1);

    state_t                 state, state_nxt;
    logic [OUT_WIDTH-1:0]   acc, acc_wr, out_reg;
    logic                   out_valid;
    logic                   rst_done;
    logic                   flush_silent, silent_nxt;
    logic                   load_partial, done_nxt;
    logic                   accept, complete, out_free, flush_req, timeout_fire;
    logic                   lane_empty_after, out_busy_after;

    assign fifo_wr_en   = out_valid && !fifo_full;
    assign fifo_wr_data = out_reg;
    assign out_free     = !out_valid || fifo_wr_en;
    assign in_ready     = rst_done && (state == FILL)
                          && ((lane_cnt != LAST_LANE) || out_free)
                          && !((THROTTLE_ON_AF != 0) && fifo_almost_full);
    assign accept       = in_valid && in_ready;
    assign complete     = accept && (lane_cnt == LAST_LANE);
    assign flush_req    = flush || timeout_fire;

    // Occupancy as it will be after this edge, so a same-cycle accept is folded into the flush.
    assign lane_empty_after = complete || ((lane_cnt == '0) && !accept);
    assign out_busy_after   = complete || (out_valid && !fifo_wr_en);

`ifdef FIFO_WR_PACKER_TIMEOUT_EN
    fifo_wr_packer_idle_timer #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk      (wr_clk),
        .rst_n    (wr_rst_n),
        .run      (lane_cnt != '0),
        .clear    (accept || (state != FILL)),
        .expire_c (timeout_fire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout_fire   = 1'b0;
`endif

    // Accumulator with the current lane overwritten by the incoming word.
    always_comb begin
        acc_wr = acc;
        for (int unsigned k = 0; k < PACK_RATIO; k++) begin
            if (lane_cnt == LANE_W'(k)) begin
                acc_wr[k*IN_WIDTH +: IN_WIDTH] = in_data;
            end
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        load_partial = 1'b0;
        done_nxt     = 1'b0;
        silent_nxt   = flush_silent;
        case (state)
            FILL: begin
                if (flush_req) begin
                    if (lane_empty_after && !out_busy_after) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt  = FLUSH;
                        silent_nxt = !flush;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    load_partial = (lane_cnt != '0);
                    state_nxt    = DRAIN;
                end
            end
            DRAIN: begin
                if (out_free) begin
                    done_nxt   = !flush_silent;
                    silent_nxt = 1'b0;
                    state_nxt  = FILL;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // Accumulator, output register and counters.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            acc          <= '0;
            out_reg      <= '0;
            out_valid    <= 1'b0;
            lane_cnt     <= '0;
            word_cnt     <= '0;
            flush_done   <= 1'b0;
            flush_silent <= 1'b0;
            rst_done     <= 1'b0;
        end else begin
            rst_done     <= 1'b1;
            flush_done   <= done_nxt;
            flush_silent <= silent_nxt;
            if (fifo_wr_en) begin
                word_cnt <= word_cnt + WORD_CNT_W'(1);
            end
            if (complete) begin
                out_reg   <= acc_wr;
                out_valid <= 1'b1;
                acc       <= '0;
                lane_cnt  <= '0;
            end else if (load_partial) begin
                out_reg   <= acc;
                out_valid <= 1'b1;
                acc       <= '0;
                lane_cnt  <= '0;
            end else begin
                if (fifo_wr_en) begin
                    out_valid <= 1'b0;
                end
                if (accept) begin
                    acc      <= acc_wr;
                    lane_cnt <= lane_cnt + LANE_W'(1);
                end
            end
        end
    end

endmodule
